// File: rtl/bcd_ex3_pkg.sv
// Shared types and constants for the time-multiplexed BCD to Excess-3 sequencer.
package bcd_ex3_pkg;

  localparam int          DIGIT_W  = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  EX3_BIAS = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_ex3_if.sv
// Valid/ready word interface: producer side (BCD in) and consumer side (Excess-3 out).
interface bcd_ex3_if
  import bcd_ex3_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [DIGIT_W*DIGITS-1:0] bcd_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [DIGIT_W*DIGITS-1:0] ex_o;
  logic                      err_o;

  modport master (
    output in_valid_i, bcd_i, out_ready_i,
    input  in_ready_o, out_valid_o, ex_o, err_o
  );

  modport slave (
    input  in_valid_i, bcd_i, out_ready_i,
    output in_ready_o, out_valid_o, ex_o, err_o
  );

endinterface

// File: rtl/bcd_ex3_digit.sv
// Single-digit BCD to Excess-3 converter in gate form; only valid for inputs 0..9.
module bcd_ex3_digit (
  input  logic [3:0] bcd,
  output logic [3:0] ex
);

  logic b1_or_b0;

  // Don't-care minimisation over the unused codes 10..15.
  assign b1_or_b0 = bcd[1] | bcd[0];
  assign ex[3]    = bcd[3] | (bcd[2] & b1_or_b0);
  assign ex[2]    = bcd[2] ^ b1_or_b0;
  assign ex[1]    = ~(bcd[1] ^ bcd[0]);
  assign ex[0]    = ~bcd[0];

endmodule

// File: rtl/bcd_ex3_seq.sv
// Converts a packed BCD word to Excess-3 one digit per clock through a single
// shared converter; digits above 9 produce a zero field and set a sticky error.
module bcd_ex3_seq
  import bcd_ex3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  bcd_ex3_if.slave   bus
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state_q;
  logic [W-1:0]       word_q;
  logic [W-1:0]       ex_q;
  logic               err_q;
  logic [IDX_W-1:0]   idx_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [DIGIT_W-1:0] digit;
  logic [DIGIT_W-1:0] digit_ex;
  logic               digit_bad;
  logic               last_digit;

  assign digit      = word_q[idx_q*DIGIT_W +: DIGIT_W];
  assign digit_bad  = (digit > BCD_MAX);
  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

  bcd_ex3_digit u_digit (
    .bcd (digit),
    .ex  (digit_ex)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      word_q      <= '0;
      ex_q        <= '0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            word_q     <= bus.bcd_i;
            ex_q       <= '0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          ex_q[idx_q*DIGIT_W +: DIGIT_W] <= digit_bad ? '0 : digit_ex;
          if (digit_bad) begin
            err_q <= 1'b1;
          end
          if (last_digit) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          // Returning to IDLE re-opens the input only from the next cycle on.
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.ex_o        = ex_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_bcd_ex3_seq.sv
// Scoreboard bench for bcd_ex3_seq with DIGITS=4: spec vectors, stalls,
// back-to-back issue, mid-conversion reset and random words.
module tb_bcd_ex3_seq;

  localparam int DIGITS = 4;

  typedef struct packed {
    logic [15:0] ex;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_ex3_if #(.DIGITS(DIGITS)) bus ();

  bcd_ex3_seq #(.DIGITS(DIGITS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   have_acc = 0;
  bit   b2b = 0;
  bit   prev_ov = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Independent reference: each legal digit plus 3, illegal digits give 0 and flag err.
  function automatic exp_t model(input logic [15:0] w);
    exp_t r;
    logic [3:0] d;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = w[4*k +: 4];
      if (d > 4'd9) r.err = 1'b1;
      else r.ex[4*k +: 4] = d + 4'd3;
    end
    return r;
  endfunction

  task automatic send(input logic [15:0] w, input logic [15:0] ex, input logic err);
    exp_t e;
    bit   ok;
    ok = 0;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.bcd_i      = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        e.ex = ex; e.err = err;
        sb.push_back(e);
        ok = 1;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready_o && sb.size() == 0) ok = 1;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: accept timing, output latency and scoreboard compare, sampled mid-cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (bus.in_valid_i && bus.in_ready_o) begin
        if (b2b && have_acc) check("issue_interval", cyc + 1 - acc_cyc, DIGITS + 2);
        acc_cyc  = cyc + 1;
        have_acc = 1;
      end
      if (bus.out_valid_o && !prev_ov) check("latency", cyc - acc_cyc, DIGITS);
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (sb.size() == 0) check("sb_unexpected_output", bus.ex_o, 0);
        else begin
          e = sb.pop_front();
          check("ex", bus.ex_o, e.ex);
          check("err", bus.err_o, e.err);
        end
      end
    end
    prev_ov = bus.out_valid_o;
  end

  initial begin
    logic [15:0] w;
    exp_t        m;
    bit          ok;

    bus.in_valid_i  = 1'b0;
    bus.bcd_i       = '0;
    bus.out_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready_o, 1);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_ex", bus.ex_o, 0);
    check("rst_err", bus.err_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Spec vectors, including err clearing on the following word.
    send(16'h1234, 16'h4567, 1'b0);
    send(16'h0999, 16'h3CCC, 1'b0);
    send(16'h0000, 16'h3333, 1'b0);
    send(16'h9A05, 16'hC038, 1'b1);
    send(16'h0001, 16'h3334, 1'b0);
    wait_idle();

    // Consumer stall for 3 cycles in DONE.
    bus.out_ready_i = 1'b0;
    send(16'h5678, 16'h89AB, 1'b0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid_o) ok = 1;
    end
    if (!ok) check("done_timeout", 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", bus.out_valid_o, 1);
      check("hold_ex", bus.ex_o, 16'h89AB);
      check("hold_err", bus.err_o, 0);
      check("hold_in_ready", bus.in_ready_o, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_in_ready", bus.in_ready_o, 1);
    check("post_hs_out_valid", bus.out_valid_o, 0);
    check("post_hs_ex_kept", bus.ex_o, 16'h89AB);

    // Back-to-back issue with in_valid held during CONV.
    wait_idle();
    have_acc = 0;
    b2b = 1;
    for (int i = 0; i < 4; i++) begin
      w = 16'h1111 * 16'(i + 1);
      m = model(w);
      send(w, m.ex, m.err);
    end
    wait_idle();
    b2b = 0;

    // Reset asserted while digit 2 is about to be converted.
    send(16'h4321, 16'h7654, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready_o, 1);
    check("abort_out_valid", bus.out_valid_o, 0);
    check("abort_ex", bus.ex_o, 0);
    check("abort_err", bus.err_o, 0);
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      check("abort_no_valid", bus.out_valid_o, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(16'h2468, 16'h579B, 1'b0);
    wait_idle();

    // Random words, half with every digit forced legal.
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom);
      if (i % 2 == 0)
        for (int k = 0; k < DIGITS; k++) w[4*k +: 4] = w[4*k +: 4] % 4'd10;
      m = model(w);
      send(w, m.ex, m.err);
    end
    wait_idle();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1);
  end

endmodule
